// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the programmable slow-clock rate controller:
// controller state encoding, counter width and the default rate table.
package div_ctrl_pkg;

  localparam int CNT_W = 32;

  // Default divide limits. Tick period is limit+1 clock cycles.
  localparam logic [CNT_W-1:0] RATE0_DEF = 32'd6250000;
  localparam logic [CNT_W-1:0] RATE1_DEF = 32'd3125000;
  localparam logic [CNT_W-1:0] RATE2_DEF = 32'd12500000;
  localparam logic [CNT_W-1:0] RATE3_DEF = 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/div_counter.sv
// Single divider counter: counts 0..limit, flags the terminal count and
// toggles a square-wave output there. The limit register only changes on
// an explicit load, so the owner decides when a new rate takes effect.
module div_counter
  import div_ctrl_pkg::*;
#(
  parameter int             W           = CNT_W,
  parameter logic [W-1:0]   RESET_LIMIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] limit_in,
  output logic         tc,
  output logic         clk_div
);

  logic [W-1:0] r_count;
  logic [W-1:0] r_limit;
  logic         r_clk_div;

  // Equality compare only: a limit below the count simply wraps through 2^W.
  assign tc      = en & (r_count == r_limit);
  assign clk_div = r_clk_div;

  // Count while enabled; wrap to zero and toggle the divided clock at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_count   <= '0;
      r_clk_div <= 1'b0;
    end else if (clr) begin
      r_count   <= '0;
      r_clk_div <= 1'b0;
    end else if (en) begin
      if (tc) begin
        r_count   <= '0;
        r_clk_div <= ~r_clk_div;
      end else begin
        r_count   <= r_count + W'(1);
      end
    end
  end

  // Active limit register, replaced only when the controller requests a reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_limit <= RESET_LIMIT;
    end else if (load) begin
      r_limit <= limit_in;
    end
  end

endmodule

// File: rtl/div_rate_ctrl.sv
// Programmable rate controller: start/pause/stop sequencing of one divider,
// a small writable table of divide limits, and reloads of the active limit
// only at terminal count so clk_div never has a short or long half-period.
module div_rate_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int               CNT_W     = div_ctrl_pkg::CNT_W,
  parameter int               NUM_RATES = 4,
  parameter logic [CNT_W-1:0] RATE0     = CNT_W'(RATE0_DEF),
  parameter logic [CNT_W-1:0] RATE1     = CNT_W'(RATE1_DEF),
  parameter logic [CNT_W-1:0] RATE2     = CNT_W'(RATE2_DEF),
  parameter logic [CNT_W-1:0] RATE3     = CNT_W'(RATE3_DEF),
  localparam int              SEL_W     = $clog2(NUM_RATES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [SEL_W-1:0] rate_sel,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             tick,
  output logic             clk_div,
  output logic             busy,
  output logic [1:0]       state
);

  function automatic logic [CNT_W-1:0] rate_init(input int idx);
    case (idx % 4)
      0:       return RATE0;
      1:       return RATE1;
      2:       return RATE2;
      default: return RATE3;
    endcase
  endfunction

  state_t           r_state;
  logic             r_tick;
  logic             r_busy;
  logic [CNT_W-1:0] r_table [NUM_RATES];
  logic [SEL_W-1:0] r_active_idx;
  logic             r_dirty;

  logic             w_cfg_fire;
  logic             w_en;
  logic             w_clr;
  logic             w_start_idle;
  logic             w_reload_req;
  logic             w_load;
  logic             w_tc;
  logic [CNT_W-1:0] w_limit_sel;

  // The table never back-pressures writes.
  assign cfg_ready    = 1'b1;
  assign w_cfg_fire   = cfg_valid & cfg_ready;

  // Pre-write table contents: a write landing on a reload edge is seen one period later.
  assign w_limit_sel  = r_table[rate_sel];

  // Counting is frozen on the pause/stop edge itself, so HOLD keeps the count it was paused at.
  assign w_en         = (r_state == RUN) & ~stop & ~pause;
  assign w_clr        = stop | (r_state == IDLE);
  assign w_start_idle = (r_state == IDLE) & start & ~stop;

  // Reload when the selection moved or the active entry was rewritten since the last load.
  assign w_reload_req = (rate_sel != r_active_idx) | r_dirty;
  assign w_load       = w_start_idle | (w_tc & w_reload_req);

  assign tick         = r_tick;
  assign busy         = r_busy;
  assign state        = r_state;

  div_counter #(
    .W           (CNT_W),
    .RESET_LIMIT (RATE0)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (w_en),
    .clr      (w_clr),
    .load     (w_load),
    .limit_in (w_limit_sel),
    .tc       (w_tc),
    .clk_div  (clk_div)
  );

  // Rate table: small register file with defined power-up contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this table is a handful of flops whose reset values are part of the contract, so resetting it is intended; a RAM-backed table would not be reset.
      for (int i = 0; i < NUM_RATES; i++) begin
        r_table[i] <= rate_init(i);
      end
    end else if (w_cfg_fire) begin
      r_table[cfg_idx] <= cfg_limit;
    end
  end

  // Track which entry the counter's limit came from and whether it has since been rewritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active_idx <= '0;
      r_dirty      <= 1'b0;
    end else if (w_load) begin
      r_active_idx <= rate_sel;
      // A write to the newly loaded entry on this same edge was not captured yet.
      r_dirty      <= w_cfg_fire & (cfg_idx == rate_sel);
    end else if (w_cfg_fire && (cfg_idx == r_active_idx)) begin
      r_dirty      <= 1'b1;
    end
  end

  // Control FSM with registered tick/busy/state; stop beats pause beats start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tick <= w_tc;
      if (stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              r_state <= HOLD;
            end
          end
          HOLD: begin
            if (!pause && start) begin
              r_state <= RUN;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Bench for div_rate_ctrl: directed scenarios followed by random pulses and
// table writes. A cycle-level reference model of the rate controller's
// behaviour queues the expected outputs; a monitor compares them after each
// rising edge.
module tb_div_rate_ctrl;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        pause     = 1'b0;
  logic        stop      = 1'b0;
  logic [1:0]  rate_sel  = 2'd0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_idx   = 2'd0;
  logic [31:0] cfg_limit = 32'd0;
  logic        cfg_ready;
  logic        tick;
  logic        clk_div;
  logic        busy;
  logic [1:0]  state;

  div_rate_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .rate_sel  (rate_sel),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_limit (cfg_limit),
    .tick      (tick),
    .clk_div   (clk_div),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic       clk_div;
    logic       busy;
    logic [1:0] state;
    logic       cfg_ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Values applied at the next falling edge.
  logic       rst_level = 1'b0;
  logic [1:0] sel_next  = 2'd0;

  // Reference model: controller mode (0 idle, 1 running, 2 held), position in
  // the period, active limit, divided clock, tick and the limit table.
  int          m_mode;
  logic [31:0] m_cnt;
  logic [31:0] m_lim;
  logic        m_cdiv;
  logic        m_tick;
  logic [31:0] m_tab [4];

  function automatic obs_t sample_dut();
    obs_t o;
    o.tick      = tick;
    o.clk_div   = clk_div;
    o.busy      = busy;
    o.state     = state;
    o.cfg_ready = cfg_ready;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s t=%0t got tick=%b clk_div=%b busy=%b state=%0d cfg_ready=%b, required tick=%b clk_div=%b busy=%b state=%0d cfg_ready=%b",
               name, $time, act.tick, act.clk_div, act.busy, act.state, act.cfg_ready,
               req.tick, req.clk_div, req.busy, req.state, req.cfg_ready);
    end
  endtask

  // Advance the model by one rising edge using the inputs now on the pins.
  task automatic model_step();
    logic        at_tc;
    logic [31:0] next_lim;
    if (!reset) begin
      m_mode   = 0;
      m_cnt    = 32'd0;
      m_lim    = 32'd6250000;
      m_cdiv   = 1'b0;
      m_tick   = 1'b0;
      m_tab[0] = 32'd6250000;
      m_tab[1] = 32'd3125000;
      m_tab[2] = 32'd12500000;
      m_tab[3] = 32'd1;
      return;
    end
    // The period ends when the running count has reached the limit and
    // neither stop nor pause intervenes on this edge.
    at_tc    = (m_mode == 1) && !stop && !pause && (m_cnt == m_lim);
    next_lim = m_tab[rate_sel];   // table as it stood before any write on this edge
    m_tick   = at_tc;
    if (stop) begin
      m_mode = 0;
      m_cnt  = 32'd0;
      m_cdiv = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_lim  = next_lim;
      end
    end else if (m_mode == 1) begin
      if (pause)      m_mode = 2;
      else if (at_tc) begin
        m_cnt  = 32'd0;
        m_cdiv = ~m_cdiv;
        m_lim  = next_lim;
      end else        m_cnt  = m_cnt + 32'd1;
    end else begin
      if (!pause && start) m_mode = 1;
    end
    if (cfg_valid) m_tab[cfg_idx] = cfg_limit;
  endtask

  // Apply one cycle of stimulus at the falling edge and queue what must follow the next rising edge.
  task automatic drive(input logic s, input logic p, input logic k,
                       input logic cv = 1'b0, input logic [1:0] ci = 2'd0,
                       input logic [31:0] cl = 32'd0);
    obs_t e;
    @(negedge clk);
    reset     = rst_level;
    rate_sel  = sel_next;
    start     = s;
    pause     = p;
    stop      = k;
    cfg_valid = cv;
    cfg_idx   = ci;
    cfg_limit = cl;
    model_step();
    e.tick      = m_tick;
    e.clk_div   = m_cdiv;
    e.busy      = (m_mode != 0);
    e.state     = 2'(m_mode);
    e.cfg_ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [31:0] val);
    drive(1'b0, 1'b0, 1'b0, 1'b1, idx, val);
  endtask

  // Monitor: compare the queued expectation just after every rising edge.
  always begin
    obs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", sample_dut(), e);
    end
  end

  initial begin
    obs_t rst_obs;
    rst_obs           = '0;
    rst_obs.cfg_ready = 1'b1;

    // Reset, then release.
    rst_level = 1'b0;
    idle(2);
    rst_level = 1'b1;
    idle(2);

    // L=1 from the reset table: tick every 2nd cycle, clk_div period 4.
    sel_next = 2'd3;
    drive(1'b1, 1'b0, 1'b0);
    idle(12);
    drive(1'b0, 1'b0, 1'b1);

    // L=3, then switch to entry 3 at count=1 after two ticks.
    write_entry(2'd0, 32'd3);
    sel_next = 2'd0;
    drive(1'b1, 1'b0, 1'b0);
    idle(9);
    sel_next = 2'd3;
    idle(12);
    drive(1'b0, 1'b0, 1'b1);

    // Pause at count=2, hold 5 cycles, resume.
    sel_next = 2'd0;
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 1'b0);
    idle(5);
    drive(1'b1, 1'b0, 1'b0);
    idle(6);

    // Stop, pause and start together while running.
    drive(1'b1, 1'b1, 1'b1);
    idle(2);

    // Write the active entry on the same edge as a terminal count.
    drive(1'b1, 1'b0, 1'b0);
    idle(3);
    write_entry(2'd0, 32'd1);
    idle(14);
    drive(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-period with clk_div high.
    write_entry(2'd0, 32'd3);
    drive(1'b1, 1'b0, 1'b0);
    idle(5);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    rst_level = 1'b0;
    #1;
    check("async_reset", sample_dut(), rst_obs);
    idle(2);
    rst_level = 1'b1;
    idle(1);

    // Table restored: entry 3 runs at L=1 again, entry 0 is long again.
    sel_next = 2'd3;
    drive(1'b1, 1'b0, 1'b0);
    idle(8);
    drive(1'b0, 1'b0, 1'b1);
    sel_next = 2'd0;
    drive(1'b1, 1'b0, 1'b0);
    idle(20);
    drive(1'b0, 1'b0, 1'b1);

    // Random pulses, rate changes and table writes with short limits (including 0).
    for (int i = 0; i < 4; i++) write_entry(2'(i), 32'($urandom_range(0, 4)));
    for (int i = 0; i < 500; i++) begin
      logic s, p, k, cv;
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 15) == 0);
      k  = ($urandom_range(0, 39) == 0);
      cv = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) sel_next = 2'($urandom_range(0, 3));
      drive(s, p, k, cv, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 5)));
    end

    // Let the monitor consume the last expectation, then confirm nothing is left.
    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain got %0d pending, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/div_rate_ctrl.md
# div_rate_ctrl

Programmable rate controller for the system's slow-clock generation. It holds a small table of divide limits, sequences a single divider counter through start/pause/stop, and switches rates glitch-free at period boundaries. It drives both a one-cycle `tick` enable and a square-wave `clk_div` to downstream display, timer and FSM logic. It sits between the board clock domain and every block that previously owned a fixed-rate divider.

## Interface

- `CNT_W`, 32: counter and limit width.
- `NUM_RATES`, 4: rate table depth; index width is `SEL_W = $clog2(NUM_RATES)`.
- `RATE0`..`RATE3`, 6250000 / 3125000 / 12500000 / 1: reset values of the table entries.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: pulse. Starts counting from IDLE, or resumes from HOLD.
- `pause` in 1: pulse. Freezes the counter (RUN → HOLD).
- `stop` in 1: pulse. Returns to IDLE from any state.
- `rate_sel` in SEL_W: requested active table entry. Sampled every cycle.
- `cfg_valid` in 1: table write request.
- `cfg_ready` out 1: table write accept. Always 1 out of reset.
- `cfg_idx` in SEL_W: table entry to write.
- `cfg_limit` in CNT_W: new limit value.
- `tick` out 1: one-cycle pulse at each terminal count.
- `clk_div` out 1: toggles at each terminal count.
- `busy` out 1: high in RUN or HOLD.
- `state` out 2: encoded FSM state (IDLE=0, RUN=1, HOLD=2).

## Operation

- **Reset values:**
  - `tick`=0, `clk_div`=0, `busy`=0, `state`=IDLE, `cfg_ready`=1.
  - count=0, active index=0.
  - table[i]=RATEi.
- **IDLE:**
  - count held at 0; `clk_div` held at 0.
  - `start` → RUN. The active limit L latches `table[rate_sel]`.
- **RUN:**
  - count increments by 1 per cycle.
  - When count==L: count←0, `tick`←1 for one cycle, `clk_div` toggles.
  - Tick period is L+1 cycles; `clk_div` period is 2(L+1).
  - L=0 is legal: `tick` stays high continuously and `clk_div` toggles every cycle.
- **HOLD:**
  - count, `clk_div` and L frozen; `tick`=0.
  - `start` → RUN, continuing from the frozen count.
- **Priority when pulses coincide:** stop > pause > start.
  - `stop` in any state: count←0, `clk_div`←0, `tick`←0, state←IDLE on the same edge.
  - `pause` in IDLE is ignored.
  - `start` in RUN is ignored.
- **Rate change:**
  - When `rate_sel` ≠ active index in RUN, the new limit `table[rate_sel]` is loaded only at the next terminal count (the edge where count==L).
  - The terminating period completes at the old L; the next period uses the new limit.
  - No truncated or stretched `clk_div` half-period is permitted.
  - Rate changes requested in HOLD are deferred to the first terminal count after resume.
- **Table write:**
  - Occurs on `cfg_valid & cfg_ready`.
  - Writing the active entry does not change L mid-period. L reloads from the table at the next terminal count, reusing the rate-change path.
  - If a write and a terminal count fall on the same edge, the reload uses the pre-write value; the new value takes effect one period later.
- **Comparison:** equality only. If an external write makes L < count, which is impossible with deferred reload, count wraps at 2^CNT_W.

## Timing

- `start` sampled at edge E0: count is 0 after E0 and equals k after edge E0+k.
- First `tick` is high in the cycle following edge E0+L+1. `clk_div` rises on that same edge.
- `tick`, `clk_div`, `busy` and `state` are registered; there are no combinational paths from any input.
- `stop` takes effect at the sampling edge; outputs read reset values one cycle later.
- Asynchronous reset assertion mid-count clears all state immediately, independent of `clk`.

## Structure

- Shared package `div_ctrl_pkg` contains:
  - the state enum (IDLE/RUN/HOLD);
  - `CNT_W`;
  - the default RATE constants.
- Sub-module `div_counter` contains the counter, terminal-count compare, `clk_div` toggle and limit register. Its ports are `en`, `clr`, `load`, `limit_in`, and outputs `tc` and `clk_div`.
- `div_rate_ctrl` owns the FSM, the rate table and the pending-reload logic.

## Test plan

- Reset, then `start` with `rate_sel`=3 (L=1):
  - `tick` high every 2nd cycle;
  - `clk_div` period 4 cycles;
  - first `tick` in cycle after E0+2.
- Write table[0]=3, select 0, start. After 2 ticks, switch `rate_sel` to 3 at count=1:
  - count continues to 3;
  - the following ticks are spaced 2 cycles;
  - no short `clk_div` half-period.
- RUN with L=3; `pause` at count=2; hold 5 cycles; `start`:
  - count resumes at 2;
  - `tick` after 2 more edges;
  - `clk_div` unchanged during HOLD.
- `stop`, `pause` and `start` asserted in the same cycle during RUN:
  - IDLE next cycle;
  - `clk_div`=0, count=0, `busy`=0.
- Write to the active entry on the same edge as a terminal count: the next period uses the old value and the one after uses the new value.
- Assert `reset` mid-period with `clk_div`=1: outputs clear immediately and the table returns to RATE0..RATE3.
